// File: rtl/auto_player_pkg.sv
// Shared types, constants and helpers for the auto_player block.
package auto_player_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        NEWGAME = 3'd1,
        WAIT_C  = 3'd2,
        PICK    = 3'd3,
        ENTER   = 3'd4,
        RELEASE = 3'd5,
        DONE    = 3'd6
    } ap_state_t;

    localparam logic [3:0] NUM_MAX    = 4'd9;
    localparam logic [4:0] TARGET_SUM = 5'd15;
    localparam logic [8:0] ALL_TAKEN  = 9'h1FF;

    // One-hot mask for a board number 1..9; anything else maps to zero.
    function automatic logic [8:0] num_mask(input logic [3:0] num);
        logic [8:0] m;
        if ((num >= 4'd1) && (num <= NUM_MAX)) begin
            m = 9'd1 << (num - 4'd1);
        end else begin
            m = 9'd0;
        end
        return m;
    endfunction

endpackage

// File: rtl/move_chooser.sv
// Combinational move selection for the auto player.
// Build option: AUTO_PLAYER_STRATEGY_EN enables win/block/centre priority;
// without it the lowest free number is always chosen.
module move_chooser
    import auto_player_pkg::*;
(
    input  logic [8:0] hTaken,
    input  logic [8:0] cTaken,
    output logic [3:0] pick
);

    logic [8:0] free_s;

    assign free_s = ~(hTaken | cTaken);

    // Lowest-numbered member of a 9-bit number set, zero when empty.
    function automatic logic [3:0] lowest_num(input logic [8:0] v);
        logic [3:0] num;
        logic       found;
        num   = 4'd0;
        found = 1'b0;
        for (int n = 1; n <= int'(NUM_MAX); n++) begin
            if (!found && ((v & num_mask(4'(n))) != 9'd0)) begin
                num   = 4'(n);
                found = 1'b1;
            end else begin
                num   = num;
            end
        end
        return num;
    endfunction

`ifdef AUTO_PLAYER_STRATEGY_EN
    // Free numbers n that finish a pair a+b+n=15 held by the owner.
    function automatic logic [8:0] pair_hits(input logic [8:0] owned, input logic [8:0] fr);
        logic [8:0] hits;
        hits = 9'd0;
        for (int n = 1; n <= int'(NUM_MAX); n++) begin
            for (int a = 1; a <= int'(NUM_MAX); a++) begin
                for (int b = a + 1; b <= int'(NUM_MAX); b++) begin
                    if (((a + b + n) == int'(TARGET_SUM)) &&
                        ((owned & num_mask(4'(a))) != 9'd0) &&
                        ((owned & num_mask(4'(b))) != 9'd0) &&
                        ((fr & num_mask(4'(n))) != 9'd0)) begin
                        hits = hits | num_mask(4'(n));
                    end else begin
                        hits = hits;
                    end
                end
            end
        end
        return hits;
    endfunction

    logic [8:0] win_s;
    logic [8:0] block_s;

    assign win_s   = pair_hits(hTaken, free_s);
    assign block_s = pair_hits(cTaken, free_s);

    // Priority: own win, block engine, centre, then lowest free.
    always_comb begin
        pick = 4'd0;
        if (win_s != 9'd0) begin
            pick = lowest_num(win_s);
        end else if (block_s != 9'd0) begin
            pick = lowest_num(block_s);
        end else if (free_s[4]) begin
            pick = 4'd5;
        end else begin
            pick = lowest_num(free_s);
        end
    end
`else
    // Baseline: lowest free number.
    always_comb begin
        pick = lowest_num(free_s);
    end
`endif

endmodule

// File: rtl/auto_player.sv
// Autonomous human-side player for the sum-to-15 engine.
// Build option: AUTO_PLAYER_STRATEGY_EN (see move_chooser) selects the
// strategic chooser; timing is the same either way.
module auto_player
    import auto_player_pkg::*;
#(
    parameter int ENTER_CYCLES = 2,
    parameter int TIMEOUT      = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] cMove,
    input  logic       win,
    output logic [3:0] hMove,
    output logic       enter_L,
    output logic       newGame_L,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [8:0] hTaken,
    output logic [8:0] cTaken
);

    localparam int               TMO_W      = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT - 1);
    localparam logic [3:0]       ENTER_LAST = 4'(ENTER_CYCLES - 1);

    ap_state_t        state_r, state_s;
    logic [3:0]       enter_cnt_r, enter_cnt_s;
    logic [TMO_W-1:0] tmo_cnt_r, tmo_cnt_s;
    logic [3:0]       hmove_r, hmove_s, pick_s;
    logic             enter_l_r, newgame_l_r, busy_r, done_r;
    logic             error_r, error_s;
    logic [8:0]       htaken_r, htaken_s, ctaken_r, ctaken_s;
    logic [8:0]       cmove_mask_s;
    logic             new_move_s;

    move_chooser u_chooser (
        .hTaken (htaken_r),
        .cTaken (ctaken_r),
        .pick   (pick_s)
    );

    // A valid engine number not yet recorded counts as a fresh move.
    assign cmove_mask_s = num_mask(cMove);
    assign new_move_s   = (cmove_mask_s != 9'd0) && ((cmove_mask_s & ctaken_r) == 9'd0);

    // Next-state and next-value logic for the game sequencer.
    always_comb begin
        state_s     = state_r;
        enter_cnt_s = enter_cnt_r;
        tmo_cnt_s   = tmo_cnt_r;
        hmove_s     = hmove_r;
        error_s     = error_r;
        htaken_s    = htaken_r;
        ctaken_s    = ctaken_r;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    htaken_s = 9'd0;
                    ctaken_s = 9'd0;
                    error_s  = 1'b0;
                    state_s  = NEWGAME;
                end else begin
                    state_s  = state_r;
                end
            end
            NEWGAME: begin
                tmo_cnt_s = '0;
                state_s   = WAIT_C;
            end
            WAIT_C: begin
                if (new_move_s) begin
                    ctaken_s = ctaken_r | cmove_mask_s;
                    if ((cmove_mask_s & htaken_r) != 9'd0) begin
                        error_s = 1'b1;
                        state_s = DONE;
                    end else if (win || ((ctaken_s | htaken_r) == ALL_TAKEN)) begin
                        state_s = DONE;
                    end else begin
                        state_s = PICK;
                    end
                end else if (win) begin
                    state_s = DONE;
                end else if (tmo_cnt_r == TMO_LAST) begin
                    error_s = 1'b1;
                    state_s = DONE;
                end else begin
                    tmo_cnt_s = tmo_cnt_r + 1'b1;
                end
            end
            PICK: begin
                hmove_s     = pick_s;
                htaken_s    = htaken_r | num_mask(pick_s);
                enter_cnt_s = 4'd0;
                state_s     = ENTER;
            end
            ENTER: begin
                if (enter_cnt_r == ENTER_LAST) begin
                    state_s = RELEASE;
                end else begin
                    enter_cnt_s = enter_cnt_r + 4'd1;
                end
            end
            RELEASE: begin
                if (win || ((ctaken_r | htaken_r) == ALL_TAKEN)) begin
                    state_s = DONE;
                end else begin
                    tmo_cnt_s = '0;
                    state_s   = WAIT_C;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, counters, taken sets and registered strobes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            enter_cnt_r <= 4'd0;
            tmo_cnt_r   <= '0;
            hmove_r     <= 4'd0;
            error_r     <= 1'b0;
            htaken_r    <= 9'd0;
            ctaken_r    <= 9'd0;
            enter_l_r   <= 1'b1;
            newgame_l_r <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            enter_cnt_r <= enter_cnt_s;
            tmo_cnt_r   <= tmo_cnt_s;
            hmove_r     <= hmove_s;
            error_r     <= error_s;
            htaken_r    <= htaken_s;
            ctaken_r    <= ctaken_s;
            enter_l_r   <= (state_s != ENTER);
            newgame_l_r <= (state_s != NEWGAME);
            busy_r      <= (state_s != IDLE) && (state_s != DONE);
            done_r      <= (state_s == DONE);
        end
    end

    assign hMove     = hmove_r;
    assign enter_L   = enter_l_r;
    assign newGame_L = newgame_l_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign error     = error_r;
    assign hTaken    = htaken_r;
    assign cTaken    = ctaken_r;

endmodule
